// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC, word-addressed instruction memory and the IF/ID register.
// Branch redirects replace the wrong-path fetch with a NOP bubble.
module inst_fetch #(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     branch_taken,
  input  logic [31:0]              branch_pc,
  input  logic signed [31:0]       branch_imm,
  input  logic                     imem_we,
  input  logic [$clog2(DEPTH)-1:0] imem_waddr,
  input  logic [31:0]              imem_wdata,
  output logic [31:0]              instruction,
  output logic [31:0]              if_pc,
  output logic                     if_valid,
  output logic [31:0]              pc,
  output logic                     misalign,
  output logic [31:0]              fetch_count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] imem [DEPTH];
  logic [31:0] rdata;
  logic [31:0] target;
  logic [31:0] target_aligned;
  logic        target_bad;

  // Program load; a same-edge fetch of this word still sees the old value.
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  assign rdata          = imem[pc[AW+1:2]];
  assign target         = branch_pc + (branch_imm <<< 1);
  assign target_bad     = (target[1:0] != 2'b00);
  assign target_aligned = {target[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instruction <= NOP;
      if_pc       <= 32'h0;
      if_valid    <= 1'b0;
      misalign    <= 1'b0;
      fetch_count <= 32'h0;
    end else if (branch_taken) begin
      pc          <= target_aligned;
      instruction <= NOP;
      if_valid    <= 1'b0;
      if (target_bad) misalign <= 1'b1;
    end else if (!stall) begin
      instruction <= rdata;
      if_pc       <= pc;
      if_valid    <= 1'b1;
      pc          <= pc + 32'd4;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the single-cycle/pipelined datapath: holds the program counter, reads a word-addressed instruction memory, and registers the fetched word and its PC into an IF/ID register that drives the `instruction` input of the immediate generator and the decoder. It also applies branch redirects computed from the immediate generator's branch output and flushes the wrong-path instruction.

## Interface
- `DEPTH`, 256: instruction memory size in 32-bit words; power of two.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; multiple of 4.
- `NOP`, 32'h0000_0013: bubble word (`addi x0,x0,0`) inserted on reset/flush.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold PC and IF/ID register.
- `branch_taken`  in  1  redirect request, valid this cycle.
- `branch_pc`  in  32  byte PC of the branch instruction.
- `branch_imm`  in  32 signed  branch immediate as produced by the immediate generator (halfword units, bit 0 implicit).
- `imem_we`  in  1  program-load write enable.
- `imem_waddr`  in  log2(DEPTH)  word address for load.
- `imem_wdata`  in  32  word to load.
- `instruction`  out  32  IF/ID instruction register.
- `if_pc`  out  32  byte PC of `instruction`.
- `if_valid`  out  1  `instruction` is a real fetched word (not a bubble).
- `pc`  out  32  current fetch PC.
- `misalign`  out  1  sticky: a redirect target had bits[1:0] ≠ 0.
- `fetch_count`  out  32  number of valid instructions delivered.

## Operation
- Memory: DEPTH×32 array, combinational read at `pc[log2(DEPTH)+1:2]`; PC bits above that are ignored (address wraps modulo DEPTH words). Write is synchronous on `imem_we`.
- Target: `target = branch_pc + (branch_imm <<< 1)`, 32-bit wrapping add. If `target[1:0] != 0`: set `misalign`, load `{target[31:2],2'b00}`.
- Per rising edge, priority order:
  1. `branch_taken`: `pc <= target`; `instruction <= NOP`; `if_valid <= 0`; `if_pc` unchanged. Overrides `stall`.
  2. `stall`: all registers hold; `fetch_count` holds.
  3. else: `instruction <= imem[pc]`; `if_pc <= pc`; `if_valid <= 1`; `pc <= pc + 4` (wraps at 2^32); `fetch_count <= fetch_count + 1` (wraps).
- `imem_we` is independent of stall/branch. Same-cycle write and fetch to the same word: fetched value is the OLD word; new word visible from the next fetch.
- `misalign` clears only on reset.

## Timing
- Reset (async assert, any cycle, incl. mid-redirect): `pc=RESET_PC`, `instruction=NOP`, `if_pc=0`, `if_valid=0`, `misalign=0`, `fetch_count=0`. Memory contents are not reset.
- Fetch latency: word at `pc` appears on `instruction` one edge later; first valid word on the first edge with `rst_n=1` and no stall/branch.
- Redirect latency: `branch_taken` at edge N → bubble on `instruction` after N; word at target on `instruction` after N+1.
- `stall` held k cycles → outputs frozen exactly k edges; no fetch is lost or duplicated.
- Steady state without stalls/branches: one instruction per cycle.

## Test plan
- Reset/sequential: load words 0x00500093,0x00A00113,0x002081B3 at addr 0..2; release reset → `instruction` sequence with `if_pc` 0,4,8, `if_valid`=1, `fetch_count` 1,2,3; during reset `instruction`=0x00000013, `pc`=0.
- Stall: assert `stall` 3 cycles after fetch of addr 1 → `instruction`=0x00A00113, `if_pc`=4 for 3 cycles, then addr 2 follows; `fetch_count` increments once.
- Branch: `branch_taken`=1, `branch_pc`=8, `branch_imm`=-4 → next `instruction`=NOP, `if_valid`=0, `pc`=0; then `if_pc`=0. Repeat with `stall`=1 simultaneously → same result.
- Misalign: `branch_pc`=0, `branch_imm`=1 → target 2, `pc`=0, `misalign`=1 and stays 1 until reset.
- Wrap: DEPTH=256, `branch_imm`=512, `branch_pc`=0 → `pc`=0x400, fetched word equals imem[0]; set pc to 0xFFFFFFFC via branch → next `pc`=0.
- Write collision: write 0xDEADBEEF to word currently addressed by `pc` in fetch cycle → old word fetched; redirect back → 0xDEADBEEF fetched.
